multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl_pkg.sv | 55 +++++
 rtl/multicycle_ctrl_if.sv | 34 +++
 rtl/multicycle_ctrl_funct_dec.sv | 24 ++
 rtl/multicycle_ctrl.sv | 152 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared types for the multicycle MIPS control unit: state enum, opcode/funct
// constants and datapath select encodings.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECUTE,
        S_ALUWB,
        S_BRANCH,
        S_ADDIEX,
        S_ADDIWB,
        S_JUMP,
        S_HALT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_t;

    typedef enum logic [1:0] {
        SRCB_REGB  = 2'b00,
        SRCB_FOUR  = 2'b01,
        SRCB_IMM   = 2'b10,
        SRCB_IMMSH = 2'b11
    } srcb_t;

    typedef enum logic [1:0] {
        PC_ALU    = 2'b00,
        PC_ALUOUT = 2'b01,
        PC_JUMP   = 2'b10
    } pcsrc_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Instruction/memory handshake and datapath control bundle between the
// multicycle controller (master) and the datapath/memory (slave).
interface multicycle_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       pcen;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] alucontrol;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       mem_timeout;
    logic       illegal;

    modport master (
        input  op, funct, zero, mem_ready,
        output mem_req, iord, memwrite, irwrite, pcen, pcsrc, alusrca, alusrcb,
               alucontrol, regdst, memtoreg, regwrite, mem_timeout, illegal
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  mem_req, iord, memwrite, irwrite, pcen, pcsrc, alusrca, alusrcb,
               alucontrol, regdst, memtoreg, regwrite, mem_timeout, illegal
    );
endinterface

// File: rtl/multicycle_ctrl_funct_dec.sv
// R-type funct field to ALU operation decode; unsupported codes fall back to
// add and are flagged so the controller can trap them.
module mc_funct_dec
    import mc_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alucontrol,
    output logic       supported
);

    always_comb begin
        alucontrol = ALU_ADD;
        supported  = 1'b1;
        case (funct)
            FN_ADD:  alucontrol = ALU_ADD;
            FN_SUB:  alucontrol = ALU_SUB;
            FN_AND:  alucontrol = ALU_AND;
            FN_OR:   alucontrol = ALU_OR;
            FN_SLT:  alucontrol = ALU_SLT;
            default: supported  = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS controller with unified-memory wait handshake and timeout.
// Define MC_ILLEGAL_TRAP_EN to trap illegal opcodes/functs into HALT.
module multicycle_ctrl
    import mc_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic               clk,
    input  logic               reset,
    multicycle_ctrl_if.master  bus
);

`ifdef MC_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    localparam logic [15:0] WMAX = 16'(WAIT_MAX);

    state_t      state_q;
    logic [15:0] wait_q;
    logic        timeout_q;
    logic [2:0]  funct_alu;
    logic        funct_ok;
    logic        in_mem;

    mc_funct_dec u_funct_dec (
        .funct      (bus.funct),
        .alucontrol (funct_alu),
        .supported  (funct_ok)
    );

    assign in_mem = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            case (state_q)
                S_FETCH:   if (bus.mem_ready) state_q <= S_DECODE;
                S_DECODE: begin
                    case (bus.op)
                        OP_LW, OP_SW: state_q <= S_MEMADR;
                        OP_RTYPE:     state_q <= S_EXECUTE;
                        OP_BEQ:       state_q <= S_BRANCH;
                        OP_ADDI:      state_q <= S_ADDIEX;
                        OP_J:         state_q <= S_JUMP;
                        default:      state_q <= TRAP ? S_HALT : S_FETCH;
                    endcase
                end
                S_MEMADR:  state_q <= (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:   if (bus.mem_ready) state_q <= S_MEMWB;
                S_MEMWR:   if (bus.mem_ready) state_q <= S_FETCH;
                S_EXECUTE: state_q <= (funct_ok || !TRAP) ? S_ALUWB : S_HALT;
                S_ADDIEX:  state_q <= S_ADDIWB;
                S_HALT:    state_q <= TRAP ? S_HALT : S_FETCH;
                default:   state_q <= S_FETCH;
            endcase
        end
    end

    // Counts consecutive stalled memory cycles; timeout is sticky until reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else if (in_mem && !bus.mem_ready) begin
            if (wait_q != WMAX) wait_q <= wait_q + 16'd1;
            if (wait_q >= WMAX - 16'd1) timeout_q <= 1'b1;
        end else begin
            wait_q <= '0;
        end
    end

    // Gated by reset so every strobe drops the instant reset asserts, yet
    // mem_req appears in the very first cycle after release.
    always_comb begin
        bus.mem_req     = 1'b0;
        bus.iord        = 1'b0;
        bus.memwrite    = 1'b0;
        bus.irwrite     = 1'b0;
        bus.pcen        = 1'b0;
        bus.pcsrc       = '0;
        bus.alusrca     = 1'b0;
        bus.alusrcb     = '0;
        bus.alucontrol  = '0;
        bus.regdst      = 1'b0;
        bus.memtoreg    = 1'b0;
        bus.regwrite    = 1'b0;
        bus.mem_timeout = 1'b0;
        bus.illegal     = 1'b0;
        if (reset) begin
            bus.mem_timeout = timeout_q;
            case (state_q)
                S_FETCH: begin
                    bus.mem_req    = 1'b1;
                    bus.alusrcb    = SRCB_FOUR;
                    bus.alucontrol = ALU_ADD;
                    bus.irwrite    = bus.mem_ready;
                    bus.pcen       = bus.mem_ready;
                end
                S_DECODE: begin
                    bus.alusrcb    = SRCB_IMMSH;
                    bus.alucontrol = ALU_ADD;
                end
                S_MEMADR, S_ADDIEX: begin
                    bus.alusrca    = 1'b1;
                    bus.alusrcb    = SRCB_IMM;
                    bus.alucontrol = ALU_ADD;
                end
                S_MEMRD: begin
                    bus.mem_req = 1'b1;
                    bus.iord    = 1'b1;
                end
                S_MEMWB: begin
                    bus.memtoreg = 1'b1;
                    bus.regwrite = 1'b1;
                end
                S_MEMWR: begin
                    bus.mem_req  = 1'b1;
                    bus.iord     = 1'b1;
                    bus.memwrite = 1'b1;
                end
                S_EXECUTE: begin
                    bus.alusrca    = 1'b1;
                    bus.alusrcb    = SRCB_REGB;
                    bus.alucontrol = funct_alu;
                end
                S_ALUWB: begin
                    bus.regdst   = 1'b1;
                    bus.regwrite = 1'b1;
                end
                S_BRANCH: begin
                    bus.alusrca    = 1'b1;
                    bus.alusrcb    = SRCB_REGB;
                    bus.alucontrol = ALU_SUB;
                    bus.pcsrc      = PC_ALUOUT;
                    bus.pcen       = bus.zero;
                end
                S_ADDIWB:  bus.regwrite = 1'b1;
                S_JUMP: begin
                    bus.pcsrc = PC_JUMP;
                    bus.pcen  = 1'b1;
                end
                S_HALT:    bus.illegal = TRAP;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: random instruction stream against a
// per-instruction phase model; honours MC_ILLEGAL_TRAP_EN when defined.
module tb_multicycle_ctrl;
    import mc_pkg::*;

    localparam int unsigned WMAX = 255;
    localparam int P_FETCH = 0, P_DEC = 1, P_MADR = 2, P_MRD = 3, P_MWB = 4, P_MWR = 5,
                   P_EXE = 6, P_AWB = 7, P_BR = 8, P_AIEX = 9, P_AIWB = 10, P_J = 11,
                   P_HALT = 12;
`ifdef MC_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    int          total = 0;
    int          bad = 0;
    logic        m_tmo;
    int unsigned run;
    int          phq[$];
    logic [5:0]  fns[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    multicycle_ctrl_if bus();

    multicycle_ctrl #(.WAIT_MAX(WMAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [17:0] got, input logic [17:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] obs();
        return {bus.mem_req, bus.iord, bus.memwrite, bus.irwrite, bus.pcen, bus.pcsrc,
                bus.alusrca, bus.alusrcb, bus.alucontrol, bus.regdst, bus.memtoreg,
                bus.regwrite, bus.mem_timeout, bus.illegal};
    endfunction

    function automatic bit funct_ok(input logic [5:0] f);
        foreach (fns[i]) if (fns[i] == f) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [2:0] ref_alu(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic bit is_mem(input int ph);
        return (ph == P_FETCH) || (ph == P_MRD) || (ph == P_MWR);
    endfunction

    // Expected control word for one cycle of a given instruction phase.
    function automatic logic [17:0] exp_word(input int ph, input logic rdy, input logic z,
                                             input logic [5:0] f, input logic tmo);
        logic req = 0, io = 0, mw = 0, irw = 0, pce = 0, sa = 0, rd = 0, m2r = 0, rw = 0, ill = 0;
        logic [1:0] pcs = 0, sb = 0;
        logic [2:0] alu = 0;
        case (ph)
            P_FETCH: begin req = 1; sb = 2'b01; alu = 3'b010; irw = rdy; pce = rdy; end
            P_DEC:   begin sb = 2'b11; alu = 3'b010; end
            P_MADR:  begin sa = 1; sb = 2'b10; alu = 3'b010; end
            P_MRD:   begin req = 1; io = 1; end
            P_MWB:   begin m2r = 1; rw = 1; end
            P_MWR:   begin req = 1; io = 1; mw = 1; end
            P_EXE:   begin sa = 1; sb = 2'b00; alu = ref_alu(f); end
            P_AWB:   begin rd = 1; rw = 1; end
            P_BR:    begin sa = 1; sb = 2'b00; alu = 3'b110; pcs = 2'b01; pce = z; end
            P_AIEX:  begin sa = 1; sb = 2'b10; alu = 3'b010; end
            P_AIWB:  rw = 1;
            P_J:     begin pcs = 2'b10; pce = 1; end
            P_HALT:  ill = 1;
            default: ;
        endcase
        return {req, io, mw, irw, pce, pcs, sa, sb, alu, rd, m2r, rw, tmo, ill};
    endfunction

    task automatic plan(input logic [5:0] o, input logic [5:0] f);
        phq.delete();
        phq.push_back(P_FETCH);
        phq.push_back(P_DEC);
        case (o)
            6'b100011: begin phq.push_back(P_MADR); phq.push_back(P_MRD); phq.push_back(P_MWB); end
            6'b101011: begin phq.push_back(P_MADR); phq.push_back(P_MWR); end
            6'b000000: begin
                phq.push_back(P_EXE);
                if (TRAP && !funct_ok(f)) repeat (20) phq.push_back(P_HALT);
                else phq.push_back(P_AWB);
            end
            6'b000100: phq.push_back(P_BR);
            6'b001000: begin phq.push_back(P_AIEX); phq.push_back(P_AIWB); end
            6'b000010: phq.push_back(P_J);
            default:   if (TRAP) repeat (20) phq.push_back(P_HALT);
        endcase
    endtask

    // mode 0: random mem_ready; 1: always ready; 2: hold ready low for 'hold' store cycles.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int mode,
                             input int unsigned hold, input string name);
        int unsigned cyc = 0, mwr_cnt = 0;
        logic rdy;
        plan(o, f);
        while (phq.size() > 0) begin
            @(posedge clk); #1;
            if (cyc == 0) begin bus.op = o; bus.funct = f; end
            if (mode == 2 && phq[0] == P_MWR) begin rdy = (mwr_cnt >= hold); mwr_cnt++; end
            else if (mode == 1) rdy = 1'b1;
            else rdy = ($urandom_range(99) < 60);
            bus.mem_ready = rdy;
            bus.zero = 1'($urandom_range(1));
            @(negedge clk);
            chk($sformatf("%s_c%0d", name, cyc), obs(), exp_word(phq[0], rdy, bus.zero, f, m_tmo));
            if (is_mem(phq[0]) && !rdy) begin
                run++;
                if (run >= WMAX) m_tmo = 1'b1;
            end else begin
                run = 0;
                void'(phq.pop_front());
            end
            cyc++;
            if (cyc > 2000) begin
                chk({name, "_budget"}, 18'(cyc), 18'd0);
                phq.delete();
            end
        end
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        bus.mem_ready = 1'b0;
        reset = 1'b0;
        #1 chk({name, "_in_reset"}, obs(), '0);
        @(posedge clk);
        @(negedge clk);
        chk({name, "_held"}, obs(), '0);
        reset = 1'b1;
        m_tmo = 1'b0;
        run = 0;
        #1 chk({name, "_release"}, obs(), exp_word(P_FETCH, 1'b0, bus.zero, bus.funct, 1'b0));
    endtask

    initial begin
        logic [5:0] o, f;
        bus.op = '0; bus.funct = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
        m_tmo = 1'b0;
        run = 0;
        do_reset("por");

        run_instr(OP_LW,   6'd0,  1, 0, "lw_fast");
        run_instr(OP_SW,   6'd0,  1, 0, "sw_fast");
        foreach (fns[i]) run_instr(OP_RTYPE, fns[i], 1, 0, $sformatf("r%0d_fast", i));
        run_instr(OP_BEQ,  6'd0,  1, 0, "beq_fast");
        run_instr(OP_ADDI, 6'd0,  1, 0, "addi_fast");
        run_instr(OP_J,    6'd0,  1, 0, "j_fast");

        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(7))
                0: o = OP_LW;
                1: o = OP_SW;
                2: o = OP_RTYPE;
                3: o = OP_BEQ;
                4: o = OP_ADDI;
                5: o = OP_J;
                default: o = 6'($urandom);
            endcase
            f = ($urandom_range(3) == 0) ? 6'($urandom) : fns[$urandom_range(4)];
            if (TRAP && o == OP_RTYPE && !funct_ok(f)) f = fns[0];
            if (TRAP && !(o inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J})) o = OP_ADDI;
            run_instr(o, f, 0, 0, $sformatf("rnd%0d", i));
        end

`ifndef MC_ILLEGAL_TRAP_EN
        run_instr(6'b111111, 6'd0,        1, 0, "illop_nop");
        run_instr(OP_RTYPE,  6'b111111,   1, 0, "badfn_add");
`endif

        run_instr(OP_SW, 6'd0, 2, 300, "sw_timeout");
        chk("timeout_set", 18'(bus.mem_timeout), 18'd1);
        run_instr(OP_ADDI, 6'd0, 0, 0, "sticky");
        chk("timeout_sticky", 18'(bus.mem_timeout), 18'd1);

        // Reset asserted while the store strobe is live.
        @(posedge clk); #1 bus.op = OP_SW; bus.mem_ready = 1'b1;
        @(posedge clk); #1 bus.mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_rst_mwr", obs(), exp_word(P_MWR, 1'b0, bus.zero, bus.funct, m_tmo));
        do_reset("rst_mwr");
        chk("rst_tmo_clear", 18'(bus.mem_timeout), 18'd0);
        run_instr(OP_LW, 6'd0, 0, 0, "post_rst_lw");

`ifdef MC_ILLEGAL_TRAP_EN
        run_instr(6'b111111, 6'd0, 1, 0, "illop_halt");
        do_reset("rst_halt1");
        run_instr(OP_RTYPE, 6'b111111, 1, 0, "badfn_halt");
        do_reset("rst_halt2");
        run_instr(OP_BEQ, 6'd0, 0, 0, "post_halt_beq");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
